// File: rtl/updown_counter_param_if.sv
// Control and status bundle for updown_counter_param.
// The master side issues commands and the slave side (the counter) returns count and flags.
interface updown_counter_param_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             ld;
  logic             en;
  logic             mode;
  logic             sat;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             udf;

  modport master (
    output clr, ld, en, mode, sat, step, d_in,
    input  count, tc, ovf, udf
  );

  modport slave (
    input  clr, ld, en, mode, sat, step, d_in,
    output count, tc, ovf, udf
  );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulus MAX+1, programmable step, wrap/saturate
// boundary handling, and single-cycle overflow/underflow pulses.
module updown_counter_param #(
  parameter int WIDTH       = 8,
  parameter int MAX         = 255,
  parameter int SAT_DEFAULT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  updown_counter_param_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH:0]   MOD_V = (WIDTH+1)'(MAX + 1);

  if (MAX < 1 || MAX > (2**WIDTH) - 1 || (SAT_DEFAULT != 0 && SAT_DEFAULT != 1)) begin : g_bad_param
    $error("updown_counter_param: illegal MAX or SAT_DEFAULT");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH-1:0] wrap_up;
  logic [WIDTH-1:0] wrap_dn;

  always_comb begin
    s       = (bus.step > MAX_V) ? MAX_V : bus.step;
    // Sums kept one bit wider so count+s never truncates before the MAX compare.
    sum_up  = {1'b0, count_q} + {1'b0, s};
    wrap_up = WIDTH'(sum_up - MOD_V);
    wrap_dn = WIDTH'({1'b0, count_q} + MOD_V - {1'b0, s});

    count_d = count_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.ld) begin
      count_d = (bus.d_in > MAX_V) ? MAX_V : bus.d_in;
    end else if (bus.en) begin
      if (bus.mode) begin
        if (sum_up > {1'b0, MAX_V}) begin
          ovf_d   = 1'b1;
          count_d = bus.sat ? MAX_V : wrap_up;
        end else begin
          count_d = sum_up[WIDTH-1:0];
        end
      end else begin
        if (s > count_q) begin
          udf_d   = 1'b1;
          count_d = bus.sat ? '0 : wrap_dn;
        end else begin
          count_d = count_q - s;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.udf   = udf_q;
  assign bus.tc    = bus.mode ? (count_q == MAX_V) : (count_q == '0);
endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised successor to the 8-bit up/down counter with synchronous clear and load.
- Adds:
  - generic width and modulus;
  - count enable;
  - programmable step;
  - wrap or saturate boundary mode;
  - terminal-count, overflow and underflow flags.
- Used as a general-purpose event, address and timer counter inside datapath blocks.

Parameters:
- WIDTH, 8, bit width of count, d_in and step.
- MAX, 255, highest legal count value. Must satisfy 1 <= MAX <= 2^WIDTH-1.
- SAT_DEFAULT, 0, reserved documentation value; the runtime sat input governs behaviour.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- clr  input  1  synchronous clear.
- ld  input  1  synchronous load of d_in.
- en  input  1  count enable.
- mode  input  1  1 = count up, 0 = count down.
- sat  input  1  1 = saturate at boundaries, 0 = wrap modulo MAX+1.
- step  input  WIDTH  increment/decrement amount per enabled cycle.
- d_in  input  WIDTH  load value.
- count  output  WIDTH  registered count value.
- tc  output  1  combinational terminal count.
- ovf  output  1  registered one-cycle pulse on upper-boundary crossing.
- udf  output  1  registered one-cycle pulse on lower-boundary crossing.

Behaviour:
- Reset:
  - rst high forces count=0, ovf=0, udf=0 immediately, with no dependence on clk.
  - Counting resumes on the first rising edge after rst deasserts.
- Priority at each rising edge: rst > clr > ld > en > hold.
- clr: count <= 0; ovf <= 0; udf <= 0. Ignores ld, en and mode.
- ld:
  - count <= d_in if d_in <= MAX, else count <= MAX (clamped).
  - ovf and udf are cleared. No counting occurs that cycle.
- Effective step: s = min(step, MAX).
- s == 0 with en: count holds, and ovf and udf are cleared.
- en with mode=1 (up). Sum computed at WIDTH+1 bits to avoid truncation.
  - count+s <= MAX: count <= count+s; ovf <= 0.
  - count+s > MAX, sat=0: count <= count+s-(MAX+1); ovf <= 1.
  - count+s > MAX, sat=1: count <= MAX; ovf <= 1.
  - Saturate mode when already at MAX: count holds and ovf pulses again on every enabled cycle.
  - udf <= 0 throughout.
- en with mode=0 (down):
  - s <= count: count <= count-s; udf <= 0.
  - s > count, sat=0: count <= count+(MAX+1)-s; udf <= 1.
  - s > count, sat=1: count <= 0; udf <= 1.
  - ovf <= 0 throughout.
- en=0 with no clr or ld: count holds; ovf <= 0; udf <= 0. Flags are therefore single-cycle pulses per offending cycle.
- tc = (mode && count==MAX) || (!mode && count==0). Purely combinational; it follows mode changes immediately.
- Mode, sat and step may change on any cycle and take effect at the next edge. No pipeline; latency is 1 clock from input to count.
- rst asserted mid-count aborts immediately, with no partial update.
- Count never leaves the range 0..MAX after reset or any operation.

Test Plan:
- Async reset: count=0x37 and ovf=1, raise rst between edges -> count=0 and ovf=0 before the next edge. Hold en=1 while deasserting rst -> counting starts on the first edge after.
- Wrap up: WIDTH=8, MAX=9, sat=0, mode=1, step=3, load 0 -> count sequence 3,6,9,2. ovf=1 only in the cycle count becomes 2. tc=1 while count=9.
- Saturate down: MAX=255, sat=1, mode=0, step=16, load 0x25 -> sequence 0x15,0x05,0x00,0x00. udf pulses on each of the last two cycles. tc=1 once count=0.
- Priority: clr=1, ld=1, en=1, d_in=0x10 in the same cycle -> count=0. Next cycle clr=0 -> count=0x10.
- Load clamp and step clamp:
  - MAX=9, ld with d_in=200 -> count=9.
  - Then mode=1, sat=0, step=50 (s=9) -> count=8, ovf=1.
- Full-range wrap: MAX=255, sat=0, mode=1, step=1, count=0xFF -> count=0x00, ovf=1. mode=0 at 0x00 -> count=0xFF, udf=1. en=0 -> hold, flags=0.
